// File: rtl/pipe_front_ctrl.sv
// ============================================================================
// Module      : pipe_front_ctrl
// Description : PC register, IF/ID and ID/EX-control pipeline registers with
//               hazard hold/flush handling and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_front_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             PCWrite_i,
  input  logic             Stall_i,
  input  logic             NoOp_i,
  input  logic             Flush_i,
  input  logic [31:0]      BranchTarget_i,
  input  logic [31:0]      Instr_i,
  input  logic [6:0]       Ctrl_i,
  output logic [31:0]      PC_o,
  output logic [31:0]      IFID_PC_o,
  output logic [31:0]      IFID_Instr_o,
  output logic             IFID_Valid_o,
  output logic [6:0]       IDEX_Ctrl_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hold;
  logic redirect;

  // A branch seen during a hold is dropped; ID re-resolves it next cycle.
  assign hold     = Stall_i | PCWrite_i;
  assign redirect = Flush_i & ~hold;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      PC_o <= RESET_PC;
    end else if (!hold && start_i) begin
      PC_o <= redirect ? BranchTarget_i : PC_o + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      IFID_PC_o    <= 32'h0;
      IFID_Instr_o <= 32'h0;
      IFID_Valid_o <= 1'b0;
    end else if (Stall_i) begin
      IFID_PC_o    <= IFID_PC_o;
    end else if (redirect) begin
      IFID_Instr_o <= 32'h0;
      IFID_Valid_o <= 1'b0;
    end else begin
      IFID_PC_o    <= PC_o;
      IFID_Instr_o <= start_i ? Instr_i : 32'h0;
      IFID_Valid_o <= start_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      IDEX_Ctrl_o <= 7'h0;
    end else if (NoOp_i || !IFID_Valid_o) begin
      IDEX_Ctrl_o <= 7'h0;
    end else begin
      IDEX_Ctrl_o <= Ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      StallCnt_o <= '0;
      FlushCnt_o <= '0;
    end else begin
      if (Stall_i && (StallCnt_o != CNT_MAX)) begin
        StallCnt_o <= StallCnt_o + CNT_W'(1);
      end
      if (redirect && (FlushCnt_o != CNT_MAX)) begin
        FlushCnt_o <= FlushCnt_o + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_front_ctrl.sv
// ============================================================================
// Module      : tb_pipe_front_ctrl
// Description : Directed and randomized checks of pipe_front_ctrl against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_front_ctrl;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          PCWrite_i = 1'b0;
  logic          Stall_i = 1'b0;
  logic          NoOp_i = 1'b0;
  logic          Flush_i = 1'b0;
  logic [31:0]   BranchTarget_i = 32'h0;
  logic [31:0]   Instr_i = 32'h0;
  logic [6:0]    Ctrl_i = 7'h0;
  logic [31:0]   PC_o;
  logic [31:0]   IFID_PC_o;
  logic [31:0]   IFID_Instr_o;
  logic          IFID_Valid_o;
  logic [6:0]    IDEX_Ctrl_o;
  logic [CW-1:0] StallCnt_o;
  logic [CW-1:0] FlushCnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic        m_valid;
  logic [6:0]  m_ctrl;
  int          m_sc, m_fc;

  pipe_front_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
    .Stall_i(Stall_i), .NoOp_i(NoOp_i), .Flush_i(Flush_i),
    .BranchTarget_i(BranchTarget_i), .Instr_i(Instr_i), .Ctrl_i(Ctrl_i),
    .PC_o(PC_o), .IFID_PC_o(IFID_PC_o), .IFID_Instr_o(IFID_Instr_o),
    .IFID_Valid_o(IFID_Valid_o), .IDEX_Ctrl_o(IDEX_Ctrl_o),
    .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, advance model alongside the edge, sample at +1.
  task automatic step(input logic rst, input logic start, input logic pcw,
                      input logic stall, input logic noop, input logic flush,
                      input logic [31:0] tgt, input logic [31:0] instr,
                      input logic [6:0] ctrl);
    logic        fetch_blocked, take_branch;
    logic [31:0] n_pc, n_ifpc, n_ifinstr;
    logic        n_valid;
    logic [6:0]  n_ctrl;
    int          n_sc, n_fc;
    rst_i = rst; start_i = start; PCWrite_i = pcw; Stall_i = stall;
    NoOp_i = noop; Flush_i = flush; BranchTarget_i = tgt; Instr_i = instr;
    Ctrl_i = ctrl;
    @(posedge clk_i);
    fetch_blocked = stall || pcw;
    take_branch   = flush && !fetch_blocked;
    if (rst) begin
      n_pc = 32'h0; n_ifpc = 32'h0; n_ifinstr = 32'h0; n_valid = 1'b0;
      n_ctrl = 7'h0; n_sc = 0; n_fc = 0;
    end else begin
      if (fetch_blocked || !start) n_pc = m_pc;
      else if (take_branch)        n_pc = tgt;
      else                         n_pc = m_pc + 32'd4;
      n_ifpc = m_ifpc; n_ifinstr = m_ifinstr; n_valid = m_valid;
      if (!stall && take_branch) begin
        n_ifinstr = 32'h0; n_valid = 1'b0;
      end else if (!stall) begin
        n_ifpc = m_pc; n_ifinstr = start ? instr : 32'h0; n_valid = start;
      end
      n_ctrl = (noop || !m_valid) ? 7'h0 : ctrl;
      n_sc = stall ? ((m_sc + 1 > 15) ? 15 : m_sc + 1) : m_sc;
      n_fc = take_branch ? ((m_fc + 1 > 15) ? 15 : m_fc + 1) : m_fc;
    end
    m_pc = n_pc; m_ifpc = n_ifpc; m_ifinstr = n_ifinstr; m_valid = n_valid;
    m_ctrl = n_ctrl; m_sc = n_sc; m_fc = n_fc;
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 1, 1, 32'h200, 32'hDEAD_BEEF, 7'h7F);
    checks++;
    if (PC_o !== 32'h0 || IFID_PC_o !== 32'h0 || IFID_Instr_o !== 32'h0 ||
        IFID_Valid_o !== 1'b0 || IDEX_Ctrl_o !== 7'h0 ||
        StallCnt_o !== 4'd0 || FlushCnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset: pc=%h ifpc=%h ifi=%h v=%b ctrl=%h sc=%0d fc=%0d required all zero",
               PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, IDEX_Ctrl_o, StallCnt_o, FlushCnt_o);
    end
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 32'h0, 32'hA000_0000 + 32'(i), 7'h11);
      checks++;
      if (PC_o !== 32'(4 * (i + 1)) || IFID_PC_o !== 32'(4 * i) ||
          IFID_Valid_o !== 1'b1 || IFID_Instr_o !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: pc=%h ifpc=%h v=%b ifi=%h required pc=%h ifpc=%h v=1 ifi=%h",
                 i, PC_o, IFID_PC_o, IFID_Valid_o, IFID_Instr_o, 4 * (i + 1), 4 * i,
                 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_load_use();
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'hB000_000C, 7'h22);
    checks++;
    if (PC_o !== 32'h10 || IFID_PC_o !== 32'hC) begin
      errors++;
      $display("FAIL load_use_setup: pc=%h ifpc=%h required pc=10 ifpc=c", PC_o, IFID_PC_o);
    end
    step(0, 1, 1, 1, 1, 0, 32'h0, 32'hB000_0010, 7'h5A);
    checks++;
    if (PC_o !== 32'h10 || IFID_PC_o !== 32'hC || IFID_Instr_o !== 32'hB000_000C ||
        IFID_Valid_o !== 1'b1 || IDEX_Ctrl_o !== 7'h0 || StallCnt_o !== 4'd1) begin
      errors++;
      $display("FAIL load_use_stall: pc=%h ifpc=%h ifi=%h v=%b ctrl=%h sc=%0d required 10 c b000000c 1 0 1",
               PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, IDEX_Ctrl_o, StallCnt_o);
    end
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'hB000_0010, 7'h5A);
    checks++;
    if (PC_o !== 32'h14 || IDEX_Ctrl_o !== 7'h5A) begin
      errors++;
      $display("FAIL load_use_release: pc=%h ctrl=%h required pc=14 ctrl=5a", PC_o, IDEX_Ctrl_o);
    end
  endtask

  task automatic test_branch();
    step(0, 1, 0, 0, 0, 1, 32'h100, 32'hC000_0014, 7'h33);
    checks++;
    if (PC_o !== 32'h100 || IFID_Valid_o !== 1'b0 || IFID_Instr_o !== 32'h0 ||
        FlushCnt_o !== 4'd1) begin
      errors++;
      $display("FAIL branch: pc=%h v=%b ifi=%h fc=%0d required pc=100 v=0 ifi=0 fc=1",
               PC_o, IFID_Valid_o, IFID_Instr_o, FlushCnt_o);
    end
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'hC000_0100, 7'h44);
    checks++;
    if (IDEX_Ctrl_o !== 7'h0 || PC_o !== 32'h104) begin
      errors++;
      $display("FAIL branch_bubble: ctrl=%h pc=%h required ctrl=0 pc=104", IDEX_Ctrl_o, PC_o);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] pc_before;
    logic [CW-1:0] sc_before, fc_before;
    pc_before = PC_o; sc_before = StallCnt_o; fc_before = FlushCnt_o;
    step(0, 1, 1, 1, 0, 1, 32'h200, 32'hD000_0000, 7'h55);
    checks++;
    if (PC_o !== pc_before || FlushCnt_o !== fc_before || StallCnt_o !== sc_before + 4'd1) begin
      errors++;
      $display("FAIL stall_flush: pc=%h fc=%0d sc=%0d required pc=%h fc=%0d sc=%0d",
               PC_o, FlushCnt_o, StallCnt_o, pc_before, fc_before, sc_before + 4'd1);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 7'h0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 1, 1, 0, 0, 32'h0, 32'h0, 7'h0);
      checks++;
      if (StallCnt_o !== 4'((i > 15) ? 15 : i)) begin
        errors++;
        $display("FAIL saturation[%0d]: sc=%0d required %0d", i, StallCnt_o, (i > 15) ? 15 : i);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'hE000_0000, 7'h66);
    step(0, 1, 0, 0, 0, 0, 32'h0, 32'hE000_0004, 7'h66);
    step(0, 1, 1, 1, 0, 1, 32'h300, 32'h0, 7'h66);
    step(1, 1, 1, 1, 1, 1, 32'h300, 32'h0, 7'h66);
    checks++;
    if (PC_o !== 32'h0 || IFID_PC_o !== 32'h0 || IFID_Instr_o !== 32'h0 ||
        IFID_Valid_o !== 1'b0 || IDEX_Ctrl_o !== 7'h0 ||
        StallCnt_o !== 4'd0 || FlushCnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: pc=%h ifpc=%h ifi=%h v=%b ctrl=%h sc=%0d fc=%0d required all zero",
               PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, IDEX_Ctrl_o, StallCnt_o, FlushCnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, 7'($urandom));
      checks++;
      if (PC_o !== m_pc || IFID_PC_o !== m_ifpc || IFID_Instr_o !== m_ifinstr ||
          IFID_Valid_o !== m_valid || IDEX_Ctrl_o !== m_ctrl ||
          StallCnt_o !== 4'(m_sc) || FlushCnt_o !== 4'(m_fc)) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h ifpc=%h ifi=%h v=%b ctrl=%h sc=%0d fc=%0d required pc=%h ifpc=%h ifi=%h v=%b ctrl=%h sc=%0d fc=%0d",
                 i, PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, IDEX_Ctrl_o, StallCnt_o, FlushCnt_o,
                 m_pc, m_ifpc, m_ifinstr, m_valid, m_ctrl, m_sc, m_fc);
      end
    end
  endtask

  initial begin
    m_pc = 0; m_ifpc = 0; m_ifinstr = 0; m_valid = 0; m_ctrl = 0; m_sc = 0; m_fc = 0;
    #2;
    test_reset();
    test_seq_fetch();
    test_load_use();
    test_branch();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
